// File: rtl/rename_pkg.sv
// Shared rename-stage types and helpers for the physical-register free list.
// Widths are sized for the default machine: 128 physical / 32 architectural
// registers, which leaves a 96-entry free list.
package rename_pkg;

  localparam int unsigned NUM_PREGS_DEF = 32'd128;
  localparam int unsigned NUM_AREGS_DEF = 32'd32;
  localparam int unsigned FL_DEPTH_DEF  = NUM_PREGS_DEF - NUM_AREGS_DEF;

  localparam int unsigned PREG_W = $clog2(NUM_PREGS_DEF);
  localparam int unsigned PTR_W  = $clog2(FL_DEPTH_DEF);
  localparam int unsigned CNT_W  = $clog2(FL_DEPTH_DEF + 32'd1);

  typedef logic [PREG_W-1:0] preg_t;

  // Circular-buffer pointer: index plus a wrap bit that toggles per lap.
  typedef struct packed {
    logic             wrap;
    logic [PTR_W-1:0] idx;
  } fl_ptr_t;

  // Index advance modulo a depth that need not be a power of two.
  function automatic logic [PTR_W-1:0] idx_add(logic [PTR_W-1:0] idx,
                                               int unsigned n,
                                               int unsigned depth);
    int unsigned s;
    s = 32'(idx) + n;
    return (s >= depth) ? PTR_W'(s - depth) : PTR_W'(s);
  endfunction

  // Pointer advance: same as idx_add, toggling the wrap bit on a lap.
  function automatic fl_ptr_t ptr_add(fl_ptr_t p, int unsigned n,
                                      int unsigned depth);
    fl_ptr_t     r;
    int unsigned s;
    s = 32'(p.idx) + n;
    if (s >= depth) begin
      r.idx  = PTR_W'(s - depth);
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = PTR_W'(s);
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  // Number of entries from rd up to (not including) wr.
  function automatic int unsigned fl_count(fl_ptr_t wr, fl_ptr_t rd,
                                           int unsigned depth);
    return (wr.wrap == rd.wrap) ? (32'(wr.idx) - 32'(rd.idx))
                                : (depth - 32'(rd.idx) + 32'(wr.idx));
  endfunction

  // Population count of the low bits of a lane mask.
  function automatic int unsigned count_ones(logic [31:0] v);
    int unsigned c;
    c = 32'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/fl_lane_offset.sv
// Lane-offset prefix counter: for each lane, the number of set mask bits in
// lower-numbered lanes, plus the total. Used to compact allocate and free
// lanes onto consecutive free-list entries.
module fl_lane_offset
  import rename_pkg::*;
#(
  parameter int unsigned W  = 32'd2,
  parameter int unsigned OW = $clog2(W + 32'd1)
) (
  input  logic [W-1:0]         i_mask,
  output logic [W-1:0][OW-1:0] o_offset,
  output logic [OW-1:0]        o_total
);

  logic [OW-1:0] w_acc;

  // Running prefix sum over lanes in ascending order.
  always_comb begin
    w_acc    = '0;
    o_offset = '0;
    for (int i = 0; i < W; i++) begin
      o_offset[i] = w_acc;
      w_acc       = w_acc + OW'(i_mask[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/free_list_mp.sv
// Multi-ported physical-register free list: a circular buffer of
// NUM_PREGS-NUM_AREGS register IDs with ALLOC_W allocate lanes, FREE_W
// compacting free lanes and checkpoint/recover of the read pointer.
// Optional feature macro FREE_LIST_DUP_CHECK_EN adds a per-register free
// vector and a sticky dup_err output; offending frees are dropped.
module free_list_mp
  import rename_pkg::*;
#(
  parameter int unsigned NUM_PREGS = 32'd128,
  parameter int unsigned NUM_AREGS = 32'd32,
  parameter int unsigned ALLOC_W   = 32'd2,
  parameter int unsigned FREE_W    = 32'd2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ALLOC_W-1:0]            alloc_req,
  output logic                          alloc_ready,
  output logic [ALLOC_W-1:0][PREG_W-1:0] alloc_preg,
  input  logic [FREE_W-1:0]             free_valid,
  input  logic [FREE_W-1:0][PREG_W-1:0] free_preg,
  input  logic                          recover,
  input  logic [PTR_W:0]                recover_rd_ptr,
  output logic [PTR_W:0]                rd_ptr_out,
  output logic [CNT_W-1:0]              free_count,
  output logic                          overflow_err
`ifdef FREE_LIST_DUP_CHECK_EN
  ,
  output logic                          dup_err
`endif
);

  localparam int unsigned FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int unsigned AOFF_W   = $clog2(ALLOC_W + 32'd1);
  localparam int unsigned FOFF_W   = $clog2(FREE_W + 32'd1);

  fl_ptr_t r_rd_ptr;
  fl_ptr_t r_wr_ptr;
  preg_t   r_list [FL_DEPTH];
  logic    r_overflow_err;

  logic [CNT_W-1:0]              w_count;
  logic                          w_alloc_fire;
  logic [ALLOC_W-1:0][AOFF_W-1:0] w_alloc_off;
  logic [AOFF_W-1:0]             w_alloc_tot;
  logic [FREE_W-1:0]             w_free_lane;
  logic [FREE_W-1:0][FOFF_W-1:0] w_free_off;
  logic [FOFF_W-1:0]             w_free_tot;
  logic                          w_over;
  logic                          w_free_en;
  fl_ptr_t                       w_rec_ptr;

  assign w_count      = CNT_W'(fl_count(r_wr_ptr, r_rd_ptr, FL_DEPTH));
  assign free_count   = w_count;
  assign alloc_ready  = (32'(w_count) >= ALLOC_W);
  assign rd_ptr_out   = r_rd_ptr;
  assign overflow_err = r_overflow_err;
  assign w_rec_ptr    = fl_ptr_t'(recover_rd_ptr);

  // A recover cycle ignores allocation; otherwise all-or-nothing on ready.
  assign w_alloc_fire = alloc_ready & ~recover;

  // Overflow is judged on every requested free lane; all frees drop on it.
  assign w_over    = (32'(w_count) + count_ones(32'(free_valid))) > FL_DEPTH;
  assign w_free_en = ~w_over;

  fl_lane_offset #(.W(ALLOC_W), .OW(AOFF_W)) u_alloc_off (
    .i_mask   (alloc_req),
    .o_offset (w_alloc_off),
    .o_total  (w_alloc_tot)
  );

  fl_lane_offset #(.W(FREE_W), .OW(FOFF_W)) u_free_off (
    .i_mask   (w_free_lane),
    .o_offset (w_free_off),
    .o_total  (w_free_tot)
  );

  // Each requesting lane reads the entry past the lanes requesting below it.
  always_comb begin
    alloc_preg = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_preg[i] = r_list[idx_add(r_rd_ptr.idx, 32'(w_alloc_off[i]), FL_DEPTH)];
    end
  end

  // Pointers, list storage and sticky overflow; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= {1'b1, {PTR_W{1'b0}}};
      r_overflow_err <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_list[i] <= PREG_W'(NUM_AREGS + 32'(i));
      end
    end else begin
      if (recover) begin
        r_rd_ptr <= w_rec_ptr;
      end else if (w_alloc_fire) begin
        r_rd_ptr <= ptr_add(r_rd_ptr, 32'(w_alloc_tot), FL_DEPTH);
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      if (w_free_en) begin
        for (int j = 0; j < FREE_W; j++) begin
          if (w_free_lane[j]) begin
            r_list[idx_add(r_wr_ptr.idx, 32'(w_free_off[j]), FL_DEPTH)] <= free_preg[j];
          end
        end
        r_wr_ptr <= ptr_add(r_wr_ptr, 32'(w_free_tot), FL_DEPTH);
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_over) begin
        r_overflow_err <= 1'b1;
      end else begin
        r_overflow_err <= r_overflow_err;
      end
    end
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PREGS-1:0] r_free_vec;
  logic                 r_dup_err;
  logic [NUM_PREGS-1:0] w_free_vec_nxt;
  logic                 w_dup_hit;
  logic                 w_lane_dup;
  int unsigned          w_restore_n;
  int unsigned          w_off;

  assign dup_err     = r_dup_err;
  assign w_restore_n = fl_count(r_rd_ptr, w_rec_ptr, FL_DEPTH);

  // A free lane is rejected if its ID is architectural, already on the list,
  // or repeats an earlier valid lane in the same cycle.
  always_comb begin
    w_free_lane = '0;
    w_dup_hit   = 1'b0;
    w_lane_dup  = 1'b0;
    for (int j = 0; j < FREE_W; j++) begin
      w_lane_dup = r_free_vec[free_preg[j]] | (32'(free_preg[j]) < NUM_AREGS);
      for (int k = 0; k < j; k++) begin
        w_lane_dup = w_lane_dup | (free_valid[k] & (free_preg[k] == free_preg[j]));
      end
      w_free_lane[j] = free_valid[j] & ~w_lane_dup;
      w_dup_hit      = w_dup_hit | (free_valid[j] & w_lane_dup);
    end
  end

  // Next free vector: recover re-marks the rewound window, allocation clears,
  // accepted frees set.
  always_comb begin
    w_free_vec_nxt = r_free_vec;
    w_off          = 32'd0;
    for (int e = 0; e < FL_DEPTH; e++) begin
      w_off = (32'(e) >= 32'(w_rec_ptr.idx)) ? (32'(e) - 32'(w_rec_ptr.idx))
                                             : (32'(e) + FL_DEPTH - 32'(w_rec_ptr.idx));
      w_free_vec_nxt[r_list[e]] = w_free_vec_nxt[r_list[e]] | (recover & (w_off < w_restore_n));
    end
    for (int i = 0; i < ALLOC_W; i++) begin
      w_free_vec_nxt[alloc_preg[i]] = w_free_vec_nxt[alloc_preg[i]] & ~(w_alloc_fire & alloc_req[i]);
    end
    for (int j = 0; j < FREE_W; j++) begin
      w_free_vec_nxt[free_preg[j]] = w_free_vec_nxt[free_preg[j]] | (w_free_en & w_free_lane[j]);
    end
  end

  // Free-vector and sticky duplicate-error registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dup_err <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        r_free_vec[i] <= (32'(i) >= NUM_AREGS);
      end
    end else begin
      r_free_vec <= w_free_vec_nxt;
      if (w_dup_hit) begin
        r_dup_err <= 1'b1;
      end else begin
        r_dup_err <= r_dup_err;
      end
    end
  end
`else
  assign w_free_lane = free_valid;
`endif

endmodule

// File: tb/tb_free_list_mp.sv
// Directed bench for free_list_mp with default parameters (96-entry list).
module tb_free_list_mp;

  logic            clk;
  logic            reset;
  logic [1:0]      alloc_req;
  logic            alloc_ready;
  logic [1:0][6:0] alloc_preg;
  logic [1:0]      free_valid;
  logic [1:0][6:0] free_preg;
  logic            recover;
  logic [7:0]      recover_rd_ptr;
  logic [7:0]      rd_ptr_out;
  logic [6:0]      free_count;
  logic            overflow_err;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic            dup_err;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  free_list_mp dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req      (alloc_req),
    .alloc_ready    (alloc_ready),
    .alloc_preg     (alloc_preg),
    .free_valid     (free_valid),
    .free_preg      (free_preg),
    .recover        (recover),
    .recover_rd_ptr (recover_rd_ptr),
    .rd_ptr_out     (rd_ptr_out),
    .free_count     (free_count),
    .overflow_err   (overflow_err)
`ifdef FREE_LIST_DUP_CHECK_EN
    ,
    .dup_err        (dup_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] areq;
    logic [1:0] fval;
    logic [6:0] fp0;
    logic [6:0] fp1;
    int         e_cnt;
    int         e_p0;
    int         e_p1;
    int         e_rdy;
    int         e_rd;
    int         e_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    alloc_req  = 2'b00;
    free_valid = 2'b00;
    free_preg  = '0;
    recover    = 1'b0;
    recover_rd_ptr = 8'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Inputs, then expected outputs seen while those inputs are applied.
    vecs[0] = '{2'b00, 2'b00, 7'd0,  7'd0,  96, 32, 32, 1, 0, 0};
    vecs[1] = '{2'b11, 2'b00, 7'd0,  7'd0,  96, 32, 33, 1, 0, 0};
    vecs[2] = '{2'b10, 2'b00, 7'd0,  7'd0,  94, 34, 34, 1, 2, 0};
    vecs[3] = '{2'b01, 2'b10, 7'd0,  7'd33, 93, 35, 36, 1, 3, 0};
    vecs[4] = '{2'b00, 2'b11, 7'd32, 7'd34, 93, 36, 36, 1, 4, 0};
    vecs[5] = '{2'b01, 2'b01, 7'd35, 7'd0,  95, 36, 37, 1, 4, 0};
    vecs[6] = '{2'b00, 2'b01, 7'd36, 7'd0,  95, 37, 37, 1, 5, 0};
    vecs[7] = '{2'b00, 2'b01, 7'd77, 7'd0,  96, 37, 37, 1, 5, 0};
    vecs[8] = '{2'b00, 2'b00, 7'd0,  7'd0,  96, 37, 37, 1, 5, 1};

    do_reset();

    // Table: reset state, lane offsets, compaction, mixed alloc/free, overflow.
    for (int v = 0; v < 9; v++) begin
      alloc_req    = vecs[v].areq;
      free_valid   = vecs[v].fval;
      free_preg[0] = vecs[v].fp0;
      free_preg[1] = vecs[v].fp1;
      #1;
      chk($sformatf("v%0d.count", v), 32'(free_count), vecs[v].e_cnt);
      chk($sformatf("v%0d.preg0", v), 32'(alloc_preg[0]), vecs[v].e_p0);
      chk($sformatf("v%0d.preg1", v), 32'(alloc_preg[1]), vecs[v].e_p1);
      chk($sformatf("v%0d.ready", v), 32'(alloc_ready), vecs[v].e_rdy);
      chk($sformatf("v%0d.rdptr", v), 32'(rd_ptr_out), vecs[v].e_rd);
      chk($sformatf("v%0d.ovf", v), 32'(overflow_err), vecs[v].e_ovf);
      @(negedge clk);
    end
    idle();

    // Compaction readback: walk rd around to list[0]=33, list[1]=32.
    for (int c = 0; c < 45; c++) begin
      alloc_req = 2'b11;
      @(negedge clk);
    end
    alloc_req = 2'b01;
    @(negedge clk);
    alloc_req = 2'b11;
    #1;
    chk("cmp.preg0", 32'(alloc_preg[0]), 32'd33);
    chk("cmp.preg1", 32'(alloc_preg[1]), 32'd32);
    chk("cmp.rdptr", 32'(rd_ptr_out), 32'h80);
    chk("cmp.count", 32'(free_count), 32'd5);

    // Reset mid-operation overrides recover, alloc and free.
    @(negedge clk);
    reset = 1'b0;
    alloc_req = 2'b11;
    recover = 1'b1;
    recover_rd_ptr = 8'd5;
    free_valid = 2'b11;
    free_preg[0] = 7'd40;
    free_preg[1] = 7'd41;
    @(negedge clk);
    reset = 1'b1;
    idle();
    alloc_req = 2'b11;
    #1;
    chk("rst.count", 32'(free_count), 32'd96);
    chk("rst.rdptr", 32'(rd_ptr_out), 32'd0);
    chk("rst.ovf", 32'(overflow_err), 32'd0);
    chk("rst.preg0", 32'(alloc_preg[0]), 32'd32);
    chk("rst.preg1", 32'(alloc_preg[1]), 32'd33);
    chk("rst.ready", 32'(alloc_ready), 32'd1);

    // Drain: 48 double allocations empty the list; further requests stall.
    for (int c = 0; c < 48; c++) begin
      alloc_req = 2'b11;
      @(negedge clk);
    end
    alloc_req = 2'b00;
    #1;
    chk("drain.count", 32'(free_count), 32'd0);
    chk("drain.ready", 32'(alloc_ready), 32'd0);
    chk("drain.rdptr", 32'(rd_ptr_out), 32'h80);
    alloc_req = 2'b11;
    @(negedge clk);
    alloc_req = 2'b00;
    #1;
    chk("drain.hold_rd", 32'(rd_ptr_out), 32'h80);
    chk("drain.hold_cnt", 32'(free_count), 32'd0);

    // Wrap: allocate 95, free 95, allocate 2 straddling the end of the list.
    do_reset();
    for (int c = 0; c < 47; c++) begin
      alloc_req = 2'b11;
      @(negedge clk);
    end
    alloc_req = 2'b01;
    @(negedge clk);
    alloc_req = 2'b00;
    #1;
    chk("wrap.rd95", 32'(rd_ptr_out), 32'd95);
    chk("wrap.cnt1", 32'(free_count), 32'd1);
    for (int c = 0; c < 47; c++) begin
      free_valid   = 2'b11;
      free_preg[0] = 7'(32 + 2 * c);
      free_preg[1] = 7'(33 + 2 * c);
      @(negedge clk);
    end
    free_valid   = 2'b01;
    free_preg[0] = 7'd126;
    @(negedge clk);
    idle();
    alloc_req = 2'b11;
    #1;
    chk("wrap.cnt96", 32'(free_count), 32'd96);
    chk("wrap.preg0", 32'(alloc_preg[0]), 32'd127);
    chk("wrap.preg1", 32'(alloc_preg[1]), 32'd32);
    @(negedge clk);
    alloc_req = 2'b00;
    #1;
    chk("wrap.rdptr", 32'(rd_ptr_out), 32'h81);
    chk("wrap.cnt94", 32'(free_count), 32'd94);

    // Recover: checkpoint at 10, allocate 6, recover with a same-cycle free.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      alloc_req = 2'b11;
      @(negedge clk);
    end
    alloc_req = 2'b00;
    #1;
    chk("rec.ckpt", 32'(rd_ptr_out), 32'd10);
    for (int c = 0; c < 3; c++) begin
      alloc_req = 2'b11;
      @(negedge clk);
    end
    alloc_req = 2'b00;
    #1;
    chk("rec.rd16", 32'(rd_ptr_out), 32'd16);
    chk("rec.cnt80", 32'(free_count), 32'd80);
    recover        = 1'b1;
    recover_rd_ptr = 8'd10;
    alloc_req      = 2'b11;
    free_valid     = 2'b01;
    free_preg[0]   = 7'd32;
    @(negedge clk);
    idle();
    #1;
    chk("rec.rdptr", 32'(rd_ptr_out), 32'd10);
    chk("rec.cnt87", 32'(free_count), 32'd87);

`ifdef FREE_LIST_DUP_CHECK_EN
    // Duplicate free of register 40 is flagged and dropped.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      alloc_req = 2'b11;
      @(negedge clk);
    end
    alloc_req = 2'b01;
    @(negedge clk);
    alloc_req    = 2'b00;
    free_valid   = 2'b01;
    free_preg[0] = 7'd40;
    @(negedge clk);
    idle();
    #1;
    chk("dup.first_cnt", 32'(free_count), 32'd88);
    chk("dup.first_err", 32'(dup_err), 32'd0);
    free_valid   = 2'b01;
    free_preg[0] = 7'd40;
    @(negedge clk);
    idle();
    #1;
    chk("dup.second_cnt", 32'(free_count), 32'd88);
    chk("dup.second_err", 32'(dup_err), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
